// File: rtl/ica_pkg.sv
// ----------------------------------------------------------------------------
// ica_pkg: shared constants and types for the ICA tanh(u) generation path.
//
//   UFRAC / TFRAC      fractional bits of the input (Q16.16) and output (Q1.14)
//   LUT_BITS           index bits of the piecewise-linear table (step 0.125)
//   FRAC_BITS          interpolation fraction bits below the index
//   TANH_LUT           33 knots, round(16384 * tanh(j/8)), j = 0..32
//   u_t / th_t         signed sample and result types
//   gen_state_e        sequencing states of pe_tanhu_gen
//
// Build option: TANH_ROUND_EN (used by tanh_pwl) selects round-half-up
// interpolation instead of truncation.
// ----------------------------------------------------------------------------
package ica_pkg;

    localparam int unsigned UFRAC     = 16;
    localparam int unsigned TFRAC     = 14;
    localparam int unsigned LUT_BITS  = 5;
    localparam int unsigned FRAC_BITS = 13;

    // |u| is clamped just below 4.0, so LUT_BITS + FRAC_BITS bits cover it.
    localparam int unsigned ABS_W = LUT_BITS + FRAC_BITS;
    localparam int unsigned A_MAX = (4 << UFRAC) - 1;

    typedef logic signed [31:0] u_t;
    typedef logic signed [15:0] th_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } gen_state_e;

    localparam th_t TANH_LUT [0:32] = '{
        16'sd0,     16'sd2037,  16'sd4013,  16'sd5871,
        16'sd7571,  16'sd9087,  16'sd10406, 16'sd11533,
        16'sd12478, 16'sd13260, 16'sd13898, 16'sd14415,
        16'sd14830, 16'sd15161, 16'sd15423, 16'sd15631,
        16'sd15795, 16'sd15923, 16'sd16024, 16'sd16103,
        16'sd16165, 16'sd16213, 16'sd16251, 16'sd16280,
        16'sd16303, 16'sd16321, 16'sd16335, 16'sd16346,
        16'sd16354, 16'sd16361, 16'sd16366, 16'sd16370,
        16'sd16373
    };

endpackage

// File: rtl/tanh_pwl.sv
// ----------------------------------------------------------------------------
// tanh_pwl: scalar piecewise-linear tanh converter, Q16.16 in, Q1.14 out.
//
//   clk        clock, rising edge
//   rst        synchronous active-high reset (clears the valid bit)
//   in_valid   x is to be captured on this edge
//   x          input sample, signed Q16.16
//   out_valid  y carries a valid result this cycle
//   y          tanh(x), signed Q1.14
//
// Stage S0 (registered here): magnitude, clamp, table index/fraction, sign.
// Stage S1 (combinational here): interpolation and sign restore; the caller
// registers y, so the result lands two edges after x is presented.
//
// Build option: TANH_ROUND_EN adds half an LSB before the interpolation shift.
// ----------------------------------------------------------------------------
module tanh_pwl
    import ica_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  u_t   x,
    output logic out_valid,
    output th_t  y
);

    logic [LUT_BITS-1:0]  idx_q, idx_d;
    logic [FRAC_BITS-1:0] frac_q, frac_d;
    logic                 sign_q, sign_d;
    logic                 valid_q, valid_d;

    // S0 next-state
    logic [32:0]      x_ext;
    logic [32:0]      a_full;
    logic [ABS_W-1:0] a_clamp;

    always_comb begin
        // 33 bits so that |-2^31| is representable.
        x_ext   = {x[31], x};
        a_full  = x[31] ? (33'd0 - x_ext) : x_ext;
        a_clamp = (a_full > 33'(A_MAX)) ? ABS_W'(A_MAX) : a_full[ABS_W-1:0];

        valid_d = in_valid;
        idx_d   = idx_q;
        frac_d  = frac_q;
        sign_d  = sign_q;
        if (in_valid) begin
            idx_d  = a_clamp[ABS_W-1 -: LUT_BITS];
            frac_d = a_clamp[FRAC_BITS-1:0];
            sign_d = x[31];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            frac_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            frac_q  <= frac_d;
            sign_q  <= sign_d;
        end
    end

    // S1 interpolation
    logic [LUT_BITS:0]   idx_hi;
    th_t                 lo;
    th_t                 hi;
    logic signed [16:0]  diff;
    logic signed [29:0]  prod;
    logic signed [29:0]  prod_r;
    th_t                 m;

    always_comb begin
        idx_hi = {1'b0, idx_q} + (LUT_BITS + 1)'(1);
        lo     = TANH_LUT[idx_q];
        hi     = TANH_LUT[idx_hi];
        diff   = {hi[15], hi} - {lo[15], lo};
        // Table is monotonic, so diff >= 0 and the product stays below 2^24.
        prod   = $signed({{13{diff[16]}}, diff}) * $signed({17'd0, frac_q});
`ifdef TANH_ROUND_EN
        prod_r = prod + 30'(1 << (FRAC_BITS - 1));
`else
        prod_r = prod;
`endif
        m      = lo + th_t'(prod_r >>> FRAC_BITS);
        y      = sign_q ? -m : m;
    end

    assign out_valid = valid_q;

endmodule

// File: rtl/pe_tanhu_gen.sv
// ----------------------------------------------------------------------------
// pe_tanhu_gen: converts an NCH x NS block of whitened samples u (Q16.16)
// into tanh(u) (Q1.14), one element per cycle, for the tanh(u)*u^T stage.
//
//   clk     clock, rising edge
//   rst     synchronous active-high reset; aborts a run, clears tanhu
//   start   one-cycle request; ignored while busy or while done is high
//   u       input block, must stay stable while busy
//   tanhu   registered result block; untouched entries keep old values
//   busy    high from the accepting edge until the last write edge
//   done    one-cycle pulse, tanhu complete and stable
//
// Element k is issued on edge k+1 after the start edge and written on k+2;
// the last element and done/busy-drop share edge NCH*NS+1.
//
// Build option: TANH_ROUND_EN (see tanh_pwl) selects rounded interpolation.
// UW/TW are fixed to the u_t/th_t formats; the table indexing assumes them.
// ----------------------------------------------------------------------------
module pe_tanhu_gen
    import ica_pkg::*;
#(
    parameter int unsigned NCH = 3,
    parameter int unsigned NS  = 64,
    parameter int unsigned UW  = 32,
    parameter int unsigned TW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [UW-1:0] u     [0:NCH-1][0:NS-1],
    output logic signed [TW-1:0] tanhu [0:NCH-1][0:NS-1],
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(NS - 1);

    gen_state_e     state_q, state_d;
    logic [CHW-1:0] ch_cnt_q, ch_cnt_d;
    logic [SW-1:0]  s_cnt_q, s_cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    // Address of the element currently in the tanh_pwl S0 register.
    logic [CHW-1:0] wch_q, wch_d;
    logic [SW-1:0]  ws_q, ws_d;

    logic signed [TW-1:0] tanhu_q [0:NCH-1][0:NS-1];
    logic signed [TW-1:0] tanhu_d [0:NCH-1][0:NS-1];

    logic issue;
    logic pwl_valid;
    th_t  pwl_y;

    tanh_pwl u_tanh_pwl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .x         (u[ch_cnt_q][s_cnt_q]),
        .out_valid (pwl_valid),
        .y         (pwl_y)
    );

    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        s_cnt_d  = s_cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        issue    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is dropped, not queued.
                if (start && !done_q) begin
                    state_d  = StRun;
                    ch_cnt_d = '0;
                    s_cnt_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            StRun: begin
                issue = 1'b1;
                if (s_cnt_q == S_LAST) begin
                    s_cnt_d = '0;
                    if (ch_cnt_q == CH_LAST) begin
                        state_d = StDrain;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CHW'(1);
                    end
                end else begin
                    s_cnt_d = s_cnt_q + SW'(1);
                end
            end
            StDrain: begin
                // Last element is written on this same edge.
                if (pwl_valid) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        wch_d = issue ? ch_cnt_q : wch_q;
        ws_d  = issue ? s_cnt_q : ws_q;

        tanhu_d = tanhu_q;
        if (pwl_valid) begin
            tanhu_d[wch_q][ws_q] = pwl_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_cnt_q <= '0;
            s_cnt_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wch_q    <= '0;
            ws_q     <= '0;
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < NS; s++) begin
                    tanhu_q[c][s] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
            s_cnt_q  <= s_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wch_q    <= wch_d;
            ws_q     <= ws_d;
            tanhu_q  <= tanhu_d;
        end
    end

    assign tanhu = tanhu_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pe_tanhu_gen.sv
// Directed bench for pe_tanhu_gen: reset, mid-run abort, point values,
// clamping, edge-exact timing, ignored starts and a random sweep.
module tb_pe_tanhu_gen;

    localparam int NCH = 3;
    localparam int NS  = 64;

`ifdef TANH_ROUND_EN
    localparam int CLAMP = 16373;
`else
    localparam int CLAMP = 16372;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] u     [0:NCH-1][0:NS-1];
    logic signed [15:0] tanhu [0:NCH-1][0:NS-1];
    logic               busy;
    logic               done;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int lut [0:32];

    pe_tanhu_gen dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .u     (u),
        .tanhu (tanhu),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // done is registered, so it is stable at the falling edge.
    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic signed [31:0] x);
        longint a;
        int     idx, frac, p, m;
        a = x;
        if (a < 0) a = -a;
        if (a > 262143) a = 262143;
        idx  = int'(a >> 13);
        frac = int'(a & 8191);
        p    = (lut[idx + 1] - lut[idx]) * frac;
`ifdef TANH_ROUND_EN
        p    = p + 4096;
`endif
        m    = lut[idx] + (p >>> 13);
        return (x < 0) ? -m : m;
    endfunction

    function automatic int nonzero();
        int n = 0;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NS; s++)
                if (tanhu[c][s] !== 16'sd0) n++;
        return n;
    endfunction

    task automatic clear_u();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NS; s++)
                u[c][s] = '0;
    endtask

    task automatic random_u();
        logic signed [31:0] v;
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < NS; s++) begin
                case ($urandom_range(0, 3))
                    0: v = $urandom;
                    1: v = $urandom_range(0, 32'h48000);
                    2: v = -$signed($urandom_range(0, 32'h48000));
                    default: v = $signed($urandom_range(0, 32'h3000)) - 32'sh1800;
                endcase
                u[c][s] = v;
            end
        end
    endtask

    initial begin
        int n;
        for (int j = 0; j <= 32; j++)
            lut[j] = $rtoi($floor(16384.0 * $tanh(real'(j) / 8.0) + 0.5));

        // Reset state
        rst = 1'b1;
        start = 1'b0;
        clear_u();
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nonzero", nonzero(), 0);
        rst = 1'b0;
        tick(1);

        // Reset in the middle of a run
        random_u();
        u[0][10] = 32'h00010000;
        start = 1'b1;
        tick(1);                         // E0
        start = 1'b0;
        chk("mid_busy_e0", busy, 1);
        tick(49);                        // E49
        chk("mid_elem_written", tanhu[0][10], 12478);
        rst = 1'b1;
        tick(1);                         // E50
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_nonzero", nonzero(), 0);
        done_seen = 0;
        tick(250);
        chk("mid_no_done", done_seen, 0);
        chk("mid_idle_busy", busy, 0);

        // Point values, clamping, timing and ignored starts
        clear_u();
        u[0][0]  = 32'h00010000;
        u[1][5]  = 32'hFFFF0000;
        u[2][63] = 32'h00008000;
        u[0][1]  = 32'h7FFFFFFF;
        u[0][2]  = 32'h80000000;
        done_seen = 0;
        start = 1'b1;
        tick(1);                         // E0
        start = 1'b0;
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        tick(1);                         // E1
        chk("t00_e1", tanhu[0][0], 0);
        tick(1);                         // E2
        chk("t00_e2", tanhu[0][0], 12478);
        tick(7);                         // E9
        start = 1'b1;
        tick(1);                         // E10, ignored
        start = 1'b0;
        chk("busy_e10", busy, 1);
        tick(182);                       // E192
        chk("busy_e192", busy, 1);
        chk("done_e192", done, 0);
        start = 1'b1;
        tick(1);                         // E193, ignored (still busy)
        chk("done_e193", done, 1);
        chk("busy_e193", busy, 0);
        tick(1);                         // E194, ignored (done cycle)
        start = 1'b0;
        chk("done_e194", done, 0);
        chk("busy_e194", busy, 0);
        tick(20);
        chk("done_count", done_seen, 1);
        chk("busy_after", busy, 0);
        chk("t00", tanhu[0][0], 12478);
        chk("t1_5", tanhu[1][5], -12478);
        chk("t2_63", tanhu[2][63], 7571);
        chk("clamp_pos", tanhu[0][1], CLAMP);
        chk("clamp_neg", tanhu[0][2], -CLAMP);
        chk("others_zero", nonzero(), 5);

        // Random sweep against the interpolation model
        random_u();
        start = 1'b1;
        tick(1);                         // E0
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        chk("sweep_done", done, 1);
        chk("sweep_latency", n, 193);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NS; s++)
                chk($sformatf("sweep[%0d][%0d]", c, s), tanhu[c][s], model(u[c][s]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
